// File: rtl/breakout_pkg.sv
// Shared Breakout constants: screen limits, ball defaults, coordinate widths
// and the brick-wall collision FSM encoding.
package breakout_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int COORD_W    = 10;
    localparam int GEOM_W     = 11;
    localparam int R_BALL_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_STRIKE = 2'd2
    } wall_state_t;

    // Low edge of the ball box along one axis, clamped at 0.
    function automatic logic [GEOM_W-1:0] box_lo(input logic [COORD_W-1:0] c, input int r);
        logic [GEOM_W-1:0] c_w;
        c_w = {1'b0, c};
        return (c_w >= GEOM_W'(r)) ? c_w - GEOM_W'(r) : '0;
    endfunction

endpackage

// File: rtl/brick_wall_if.sv
// Bus between the brick wall and the game/VGA logic: ball and pixel
// coordinates in, collision result, paint data and wall status out.
interface brick_wall_if #(
    parameter int HIT_W = 2
) ();
    import breakout_pkg::*;

    // frame_tick is a one-cycle request that is taken only while busy=0;
    // hit is the one-cycle completion and bounce_x/bounce_y are qualified by it.
    logic               frame_tick;
    logic [COORD_W-1:0] x_ball;
    logic [COORD_W-1:0] y_ball;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;
    logic               brick_pixel;
    logic [HIT_W-1:0]   brick_hits;
    logic               hit;
    logic               bounce_x;
    logic               bounce_y;
    logic [7:0]         bricks_left;
    logic               all_clear;
    logic               busy;
    wall_state_t        state;

    modport master (
        output frame_tick, x_ball, y_ball, next_x, next_y,
        input  brick_pixel, brick_hits, hit, bounce_x, bounce_y,
        input  bricks_left, all_clear, busy, state
    );

    modport slave (
        input  frame_tick, x_ball, y_ball, next_x, next_y,
        output brick_pixel, brick_hits, hit, bounce_x, bounce_y,
        output bricks_left, all_clear, busy, state
    );

endinterface

// File: rtl/brick_rect.sv
// Brick index to screen rectangle; inclusive corners (x0,y0)-(x1,y1).
module brick_rect
    import breakout_pkg::*;
#(
    parameter int COLS     = 8,
    parameter int BRICK_W  = 72,
    parameter int BRICK_H  = 16,
    parameter int GAP      = 8,
    parameter int X_ORIGIN = 16,
    parameter int Y_ORIGIN = 40,
    parameter int IDX_W    = 5
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [GEOM_W-1:0] x0,
    output logic [GEOM_W-1:0] y0,
    output logic [GEOM_W-1:0] x1,
    output logic [GEOM_W-1:0] y1
);

    logic [GEOM_W-1:0] row;
    logic [GEOM_W-1:0] col;

    always_comb begin
        row = GEOM_W'(32'(idx) / COLS);
        col = GEOM_W'(32'(idx) % COLS);
        x0  = GEOM_W'(X_ORIGIN) + col * GEOM_W'(BRICK_W + GAP);
        y0  = GEOM_W'(Y_ORIGIN) + row * GEOM_W'(BRICK_H + GAP);
        x1  = x0 + GEOM_W'(BRICK_W - 1);
        y1  = y0 + GEOM_W'(BRICK_H - 1);
    end

endmodule

// File: rtl/brick_wall.sv
// Breakout brick field: per-brick hit counters, one-brick-per-frame collision
// scan with bounce-axis report, and a registered paint path for the VGA colour logic.
module brick_wall
    import breakout_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int BRICK_W  = 72,
    parameter int BRICK_H  = 16,
    parameter int GAP      = 8,
    parameter int X_ORIGIN = 16,
    parameter int Y_ORIGIN = 40,
    parameter int R_BALL   = R_BALL_DEF,
    parameter int HIT_W    = 2,
    parameter int MAX_HITS = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         restart,
    input  logic         freeze,
    brick_wall_if.slave  bus
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    wall_state_t        state;
    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [HIT_W-1:0]   hits [N];
    logic [7:0]         left;
    logic               all_clear_q;
    logic               hit_q;
    logic               bx_q;
    logic               by_q;

    // Rectangle of the brick currently under test; idx is held through STRIKE.
    logic [GEOM_W-1:0] sx0, sy0, sx1, sy1;

    brick_rect #(
        .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .GAP(GAP),
        .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .IDX_W(IDX_W)
    ) u_scan_rect (
        .idx(idx), .x0(sx0), .y0(sy0), .x1(sx1), .y1(sy1)
    );

    logic [GEOM_W-1:0] bl_x, bh_x, bl_y, bh_y;
    logic              overlap;
    logic              live;
    logic              in_x;
    logic              in_y;

    always_comb begin
        bl_x    = box_lo(cx, R_BALL);
        bl_y    = box_lo(cy, R_BALL);
        bh_x    = {1'b0, cx} + GEOM_W'(R_BALL);
        bh_y    = {1'b0, cy} + GEOM_W'(R_BALL);
        overlap = (bl_x <= sx1) && (bh_x >= sx0) && (bl_y <= sy1) && (bh_y >= sy0);
        live    = (hits[idx] != '0);
        in_x    = ({1'b0, cx} >= sx0) && ({1'b0, cx} <= sx1);
        in_y    = ({1'b0, cy} >= sy0) && ({1'b0, cy} <= sy1);
    end

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            state       <= S_IDLE;
            idx         <= '0;
            cx          <= '0;
            cy          <= '0;
            for (int i = 0; i < N; i++) hits[i] <= HIT_W'(MAX_HITS);
            left        <= 8'(N);
            all_clear_q <= 1'b0;
            hit_q       <= 1'b0;
            bx_q        <= 1'b0;
            by_q        <= 1'b0;
        end else begin
            hit_q       <= 1'b0;
            bx_q        <= 1'b0;
            by_q        <= 1'b0;
            all_clear_q <= (left == 8'd0);
            case (state)
                S_IDLE: begin
                    if (bus.frame_tick && !freeze && !all_clear_q) begin
                        cx    <= bus.x_ball;
                        cy    <= bus.y_ball;
                        idx   <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (live && overlap) begin
                        state <= S_STRIKE;
                    end else if (idx == IDX_W'(N - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_STRIKE: begin
                    hits[idx] <= hits[idx] - 1'b1;
                    if (hits[idx] == HIT_W'(1)) left <= left - 8'd1;
                    hit_q <= 1'b1;
                    // A corner strike (centre outside both spans) reverses both axes.
                    bx_q  <= in_y || !in_x;
                    by_q  <= in_x || !in_y;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [N-1:0]     on_brick;
    logic [HIT_W-1:0] pix_hits [N];
    logic [HIT_W-1:0] pix_or;
    logic             brick_pixel_q;
    logic [HIT_W-1:0] brick_hits_q;

    for (genvar g = 0; g < N; g++) begin : g_pix
        logic [GEOM_W-1:0] px0, py0, px1, py1;

        brick_rect #(
            .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .GAP(GAP),
            .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .IDX_W(IDX_W)
        ) u_rect (
            .idx(IDX_W'(g)), .x0(px0), .y0(py0), .x1(px1), .y1(py1)
        );

        assign on_brick[g] = ({1'b0, bus.next_x} >= px0) && ({1'b0, bus.next_x} <= px1) &&
                             ({1'b0, bus.next_y} >= py0) && ({1'b0, bus.next_y} <= py1) &&
                             (hits[g] != '0);
        assign pix_hits[g] = on_brick[g] ? hits[g] : '0;
    end

    // Bricks never overlap, so at most one term is non-zero.
    always_comb begin
        pix_or = '0;
        for (int i = 0; i < N; i++) pix_or = pix_or | pix_hits[i];
    end

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            brick_pixel_q <= 1'b0;
            brick_hits_q  <= '0;
        end else begin
            brick_pixel_q <= |on_brick;
            brick_hits_q  <= pix_or;
        end
    end

    assign bus.brick_pixel = brick_pixel_q;
    assign bus.brick_hits  = brick_hits_q;
    assign bus.hit         = hit_q;
    assign bus.bounce_x    = bx_q;
    assign bus.bounce_y    = by_q;
    assign bus.bricks_left = left;
    assign bus.all_clear   = all_clear_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.state       = state;

endmodule

// File: tb/tb_brick_wall.sv
// Bench for brick_wall: per-cycle comparison against a frame-level model of the
// wall, plus directed frames with hand-computed expectations.
module tb_brick_wall;
    import breakout_pkg::*;

    localparam int COLS = 8;
    localparam int N    = 32;
    localparam int BW   = 72;
    localparam int BH   = 16;
    localparam int GAP  = 8;
    localparam int XO   = 16;
    localparam int YO   = 40;
    localparam int RB   = 8;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic restart = 1'b0;
    logic freeze  = 1'b0;

    int tests = 0;
    int fails = 0;
    int hit_cnt = 0;
    int hit2_cnt = 0;

    brick_wall_if #(.HIT_W(2)) bif ();
    brick_wall_if #(.HIT_W(2)) bif2 ();

    brick_wall dut (
        .clock(clock), .reset(reset), .restart(restart), .freeze(freeze), .bus(bif)
    );

    brick_wall #(.MAX_HITS(2)) dut2 (
        .clock(clock), .reset(reset), .restart(restart), .freeze(1'b0), .bus(bif2)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required one");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bx0(input int i);
        return XO + (i % COLS) * (BW + GAP);
    endfunction

    function automatic int by0(input int i);
        return YO + (i / COLS) * (BH + GAP);
    endfunction

    function automatic bit pt_in(input int i, input int x, input int y);
        return x >= bx0(i) && x <= bx0(i) + BW - 1 && y >= by0(i) && y <= by0(i) + BH - 1;
    endfunction

    function automatic bit ball_hits(input int i, input int cx, input int cy);
        int lx, ly;
        lx = (cx < RB) ? 0 : cx - RB;
        ly = (cy < RB) ? 0 : cy - RB;
        return lx <= bx0(i) + BW - 1 && cx + RB >= bx0(i) &&
               ly <= by0(i) + BH - 1 && cy + RB >= by0(i);
    endfunction

    // ---------------- model + compare process ----------------
    int m_hits [N];
    int m_left, m_rem, m_tgt, m_cx, m_cy;
    bit m_clear;

    always @(posedge clock) begin : model
        bit c_rst, c_ft, c_frz;
        int c_xb, c_yb, c_nx, c_ny, prev_left;
        int e_hit, e_bx, e_by, e_pix, e_ph;
        bit ix, iy;
        c_rst = reset || restart;
        c_ft  = bif.frame_tick;
        c_frz = freeze;
        c_xb  = int'(bif.x_ball);
        c_yb  = int'(bif.y_ball);
        c_nx  = int'(bif.next_x);
        c_ny  = int'(bif.next_y);
        #1;
        e_pix = 0; e_ph = 0; e_hit = 0; e_bx = 0; e_by = 0;
        if (!c_rst)
            for (int i = 0; i < N; i++)
                if (m_hits[i] > 0 && pt_in(i, c_nx, c_ny)) begin
                    e_pix = 1;
                    e_ph  = m_hits[i];
                end
        if (c_rst) begin
            for (int i = 0; i < N; i++) m_hits[i] = 1;
            m_left = N; m_clear = 0; m_rem = 0; m_tgt = -1;
        end else begin
            prev_left = m_left;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0 && m_tgt >= 0) begin
                    m_hits[m_tgt]--;
                    if (m_hits[m_tgt] == 0) m_left--;
                    e_hit = 1;
                    ix = m_cx >= bx0(m_tgt) && m_cx <= bx0(m_tgt) + BW - 1;
                    iy = m_cy >= by0(m_tgt) && m_cy <= by0(m_tgt) + BH - 1;
                    e_by = ix ? 1 : 0;
                    e_bx = iy ? 1 : 0;
                    if (!ix && !iy) begin e_bx = 1; e_by = 1; end
                end
            end else if (c_ft && !c_frz && !m_clear) begin
                m_cx = c_xb; m_cy = c_yb; m_tgt = -1;
                for (int i = 0; i < N; i++)
                    if (m_tgt < 0 && m_hits[i] > 0 && ball_hits(i, m_cx, m_cy)) m_tgt = i;
                // One brick per cycle, plus the strike cycle when something is hit.
                m_rem = (m_tgt < 0) ? N : m_tgt + 2;
            end
            m_clear = (prev_left == 0);
        end
        check("hit",         32'(bif.hit),         32'(e_hit));
        check("bounce_x",    32'(bif.bounce_x),    32'(e_bx));
        check("bounce_y",    32'(bif.bounce_y),    32'(e_by));
        check("bricks_left", 32'(bif.bricks_left), 32'(m_left));
        check("all_clear",   32'(bif.all_clear),   32'(m_clear));
        check("busy",        32'(bif.busy),        32'(m_rem > 0));
        check("brick_pixel", 32'(bif.brick_pixel), 32'(e_pix));
        check("brick_hits",  32'(bif.brick_hits),  32'(e_ph));
    end

    always @(posedge clock) begin
        #2;
        if (bif.hit === 1'b1) hit_cnt++;
        if (bif2.hit === 1'b1) hit2_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic fire(input int x, input int y);
        bif.x_ball     = 10'(x);
        bif.y_ball     = 10'(y);
        bif.frame_tick = 1'b1;
        @(negedge clock);
        bif.frame_tick = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
    endtask

    task automatic paint(input int x, input int y, output logic pix, output logic [1:0] h);
        bif.next_x = 10'(x);
        bif.next_y = 10'(y);
        @(negedge clock);
        pix = bif.brick_pixel;
        h   = bif.brick_hits;
    endtask

    task automatic wait_hit(input int bound, output int n, output logic bx, output logic by);
        n = 0; bx = 1'b0; by = 1'b0;
        while (1) begin
            @(negedge clock);
            n++;
            if (bif.hit === 1'b1) begin
                bx = bif.bounce_x;
                by = bif.bounce_y;
                return;
            end
            if (n >= bound) begin
                check("hit_timeout", 32'(n), 32'(0));
                n = -1;
                return;
            end
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : directed
        logic       pix, bx, by;
        logic [1:0] h;
        int         n, base;

        bif.frame_tick = 1'b0; bif.x_ball = '0; bif.y_ball = '0;
        bif.next_x = '0; bif.next_y = '0;
        bif2.frame_tick = 1'b0; bif2.x_ball = '0; bif2.y_ball = '0;
        bif2.next_x = '0; bif2.next_y = '0;
        step(3);
        reset = 1'b0;

        // Reset state and painting
        check("rst_left",  32'(bif.bricks_left), 32'd32);
        check("rst_clear", 32'(bif.all_clear),   32'd0);
        check("rst_busy",  32'(bif.busy),        32'd0);
        paint(16, 40, pix, h);
        check("pix_16_40", 32'(pix), 32'd1);
        check("hits_16_40", 32'(h),  32'd1);
        paint(90, 40, pix, h);
        check("pix_gap", 32'(pix), 32'd0);
        check("hits_gap", 32'(h),  32'd0);

        // Two-hit brick 5 on the MAX_HITS=2 wall
        bif2.next_x = 10'd420; bif2.next_y = 10'd45;
        step(1);
        check("h2_pix_before", 32'(bif2.brick_hits), 32'd2);
        bif2.x_ball = 10'd450; bif2.y_ball = 10'd50; bif2.frame_tick = 1'b1;
        step(1);
        bif2.frame_tick = 1'b0;
        step(12);
        check("h2_hits1", 32'(hit2_cnt), 32'd1);
        check("h2_left1", 32'(bif2.bricks_left), 32'd32);
        check("h2_pix1",  32'(bif2.brick_hits),  32'd1);
        bif2.frame_tick = 1'b1;
        step(1);
        bif2.frame_tick = 1'b0;
        step(12);
        check("h2_hits2", 32'(hit2_cnt), 32'd2);
        check("h2_left2", 32'(bif2.bricks_left), 32'd31);
        check("h2_pix2",  32'(bif2.brick_pixel), 32'd0);

        // Brick 0 from below: centre inside x span only
        fire(50, 63);
        wait_hit(40, n, bx, by);
        check("b0_latency", 32'(n), 32'd2);
        check("b0_bx", 32'(bx), 32'd0);
        check("b0_by", 32'(by), 32'd1);
        check("b0_left", 32'(bif.bricks_left), 32'd31);
        paint(16, 40, pix, h);
        check("b0_gone", 32'(pix), 32'd0);

        // Side of brick 1 (brick 0 already gone)
        fire(90, 48);
        wait_hit(40, n, bx, by);
        check("side_latency", 32'(n), 32'd3);
        check("side_bx", 32'(bx), 32'd1);
        check("side_by", 32'(by), 32'd0);

        // Corner of brick 0 on a fresh wall; brick 1 and 8 also touched
        pulse_restart();
        check("restart_left", 32'(bif.bricks_left), 32'd32);
        fire(92, 60);
        wait_hit(40, n, bx, by);
        check("corner_latency", 32'(n), 32'd2);
        check("corner_bx", 32'(bx), 32'd1);
        check("corner_by", 32'(by), 32'd1);
        check("corner_left", 32'(bif.bricks_left), 32'd31);

        // Tick while busy is ignored
        pulse_restart();
        base = hit_cnt;
        fire(320, 300);
        step(3);
        check("busy_scan", 32'(bif.busy), 32'd1);
        fire(600, 120);
        step(40);
        check("busy_tick_ignored", 32'(hit_cnt - base), 32'd0);
        check("busy_done", 32'(bif.busy), 32'd0);

        // Freeze blocks the scan
        freeze = 1'b1;
        fire(600, 120);
        check("freeze_busy", 32'(bif.busy), 32'd0);
        step(40);
        check("freeze_nohit", 32'(hit_cnt - base), 32'd0);
        freeze = 1'b0;

        // Restart mid-scan aborts with no hit
        fire(600, 120);
        step(5);
        check("abort_busy_before", 32'(bif.busy), 32'd1);
        pulse_restart();
        check("abort_busy_after", 32'(bif.busy), 32'd0);
        step(40);
        check("abort_nohit", 32'(hit_cnt - base), 32'd0);
        check("abort_left", 32'(bif.bricks_left), 32'd32);

        // Clear the whole wall, one brick per frame, centre shots
        for (int i = 0; i < N; i++) begin
            fire(bx0(i) + 36, by0(i) + 8);
            wait_hit(40, n, bx, by);
            check("clear_latency", 32'(n), 32'(i + 2));
            if (n < 0) break;
        end
        check("clear_left", 32'(bif.bricks_left), 32'd0);
        check("clear_flag_hitcycle", 32'(bif.all_clear), 32'd0);
        step(1);
        check("clear_flag_next", 32'(bif.all_clear), 32'd1);
        base = hit_cnt;
        fire(52, 48);
        check("clear_no_scan", 32'(bif.busy), 32'd0);
        step(40);
        check("clear_nohit", 32'(hit_cnt - base), 32'd0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
